vga_text_console: RTL

Character-stream front end for the 40x15 text-mode VGA display. It accepts ASCII bytes over a valid/ready handshake and manages the cursor, CR/LF/backspace, line wrap and hardware scrolling. It writes character codes into the text RAM that the VGA pixel stage reads. It exports a circular top_row offset, which the display adds to its charY before addressing that RAM.

---
 rtl/vga_text_console.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vga_text_console.sv
// Character-stream front end for a 40x15 text-mode VGA display: cursor handling,
// CR/LF/BS, auto-wrap, hardware scrolling via a circular top_row, and full-screen clear.
module vga_text_console #(
    parameter int unsigned COLS   = 40,
    parameter int unsigned ROWS   = 15,
    parameter int unsigned ADDR_W = 10,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [4:0]        top_row,
    output logic [5:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StPut, StClrRow, StClrAll} state_e;

    localparam logic [5:0]        LastCol  = 6'(COLS - 1);
    localparam logic [4:0]        LastRow  = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(COLS * ROWS - 1);

    state_e              state_q;
    logic [5:0]          cur_x_q;
    logic [4:0]          cur_y_q;
    logic [4:0]          top_q;
    logic [5:0]          cnt_q;
    logic                clear_pend_q;
    logic                put_adv_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [7:0]          wr_data_q;

    logic [5:0]          row_sum;
    logic [4:0]          phys_row;
    logic [4:0]          top_next;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W-1:0]   bs_addr;
    logic [ADDR_W-1:0]   top_base;
    logic                clear_now;
    logic                printable;

    // row*40 as row*32 + row*8
    function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] row);
        return ADDR_W'({row, 5'b0}) + ADDR_W'({row, 3'b0});
    endfunction

    always_comb begin
        row_sum   = 6'(top_q) + 6'(cur_y_q);
        phys_row  = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
        top_next  = (top_q == LastRow) ? 5'd0 : top_q + 5'd1;
        cur_addr  = row_base(phys_row) + ADDR_W'(cur_x_q);
        bs_addr   = row_base(phys_row) + ADDR_W'(cur_x_q - 6'd1);
        top_base  = row_base(top_q);
        clear_now = clear_req || clear_pend_q;
        printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    end

    assign in_ready = (state_q == StIdle) && !clear_now;
    assign busy     = (state_q != StIdle);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign top_row  = top_q;
    assign cursor_x = cur_x_q;
    assign cursor_y = cur_y_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StClrAll;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            top_q        <= '0;
            cnt_q        <= '0;
            clear_pend_q <= 1'b0;
            put_adv_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            if (clear_req && state_q != StIdle) begin
                clear_pend_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (clear_now) begin
                        state_q      <= StClrAll;
                        top_q        <= '0;
                        cur_x_q      <= '0;
                        cur_y_q      <= '0;
                        clear_pend_q <= 1'b0;
                        wr_en_q      <= 1'b1;
                        wr_addr_q    <= '0;
                        wr_data_q    <= BLANK;
                    end else if (in_valid) begin
                        if (printable) begin
                            state_q   <= StPut;
                            put_adv_q <= 1'b1;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= cur_addr;
                            wr_data_q <= in_data;
                        end else if (in_data == 8'h08 && cur_x_q != 6'd0) begin
                            state_q   <= StPut;
                            put_adv_q <= 1'b0;
                            cur_x_q   <= cur_x_q - 6'd1;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= bs_addr;
                            wr_data_q <= BLANK;
                        end else if (in_data == 8'h0D) begin
                            cur_x_q <= '0;
                        end else if (in_data == 8'h0A) begin
                            cur_x_q <= '0;
                            if (cur_y_q != LastRow) begin
                                cur_y_q <= cur_y_q + 5'd1;
                            end else begin
                                top_q     <= top_next;
                                state_q   <= StClrRow;
                                cnt_q     <= '0;
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= top_base;
                                wr_data_q <= BLANK;
                            end
                        end
                    end
                end
                StPut: begin
                    state_q <= StIdle;
                    wr_en_q <= 1'b0;
                    if (put_adv_q) begin
                        if (cur_x_q != LastCol) begin
                            cur_x_q <= cur_x_q + 6'd1;
                        end else begin
                            cur_x_q <= '0;
                            if (cur_y_q != LastRow) begin
                                cur_y_q <= cur_y_q + 5'd1;
                            end else begin
                                // Old top row is recycled as the new bottom row
                                top_q     <= top_next;
                                state_q   <= StClrRow;
                                cnt_q     <= '0;
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= top_base;
                                wr_data_q <= BLANK;
                            end
                        end
                    end
                end
                StClrRow: begin
                    if (cnt_q == LastCol) begin
                        state_q <= StIdle;
                        wr_en_q <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_q + 6'd1;
                        wr_addr_q <= wr_addr_q + ADDR_W'(1);
                    end
                end
                StClrAll: begin
                    // First cycle after reset has no write pending yet
                    if (!wr_en_q) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= '0;
                        wr_data_q <= BLANK;
                    end else if (wr_addr_q == LastAddr) begin
                        state_q <= StIdle;
                        wr_en_q <= 1'b0;
                    end else begin
                        wr_addr_q <= wr_addr_q + ADDR_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
